// File: rtl/colscan_pkg.sv
// Shared types and constants for the collision lane scanner.
package colscan_pkg;

  typedef enum logic [1:0] {
    COLSCAN_IDLE = 2'd0,
    COLSCAN_SCAN = 2'd1,
    COLSCAN_DONE = 2'd2
  } colscan_state_e;

  localparam int SEL_NONE = 0;
  localparam int DWELL_W  = 4;

endpackage

// File: rtl/colscan_prio_enc.sv
// Lowest-set-bit encoder: bit i maps to lane i+1, no bits set gives 0.
module colscan_prio_enc #(
  parameter int NUM_LANES = 7,
  parameter int SEL_WIDTH = 3
) (
  input  logic [NUM_LANES-1:0] vec_i,
  output logic [SEL_WIDTH-1:0] lane_o
);

  always_comb begin
    lane_o = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (vec_i[i]) lane_o = SEL_WIDTH'(i + 1);
    end
  end

endmodule

// File: rtl/collision_lane_scanner.sv
// Steps the collision mux select over lanes 1..NUM_LANES per frame tick.
// Define COLSCAN_STICKY_EN for a sticky collision flag cleared by Clear_In.
import colscan_pkg::*;

module collision_lane_scanner #(
  parameter int NUM_LANES = 7,
  parameter int SEL_WIDTH = 3,
  parameter int DWELL     = 1
) (
  input  logic                 COLSCAN_CLOCK_50,
  input  logic                 COLSCAN_RESET_InHigh,
  input  logic                 COLSCAN_Start_In,
  input  logic [NUM_LANES-1:0] COLSCAN_LaneMask_In,
  input  logic                 COLSCAN_Hit_In,
  input  logic                 COLSCAN_Clear_In,
  output logic [SEL_WIDTH-1:0] COLSCAN_Select_Out,
  output logic [NUM_LANES-1:0] COLSCAN_HitVec_Out,
  output logic                 COLSCAN_Collision_Out,
  output logic [SEL_WIDTH-1:0] COLSCAN_FirstLane_Out,
  output logic                 COLSCAN_Busy_Out,
  output logic                 COLSCAN_Done_Out
);

  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [SEL_WIDTH-1:0] LANE_LAST  = SEL_WIDTH'(NUM_LANES);

  colscan_state_e       state_q, state_d;
  logic [SEL_WIDTH-1:0] lane_q, lane_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [NUM_LANES-1:0] accum_q, accum_d;
  logic [NUM_LANES-1:0] hitvec_q, hitvec_d;
  logic [SEL_WIDTH-1:0] first_q, first_d;
  logic [NUM_LANES-1:0] samp_vec;
  logic [SEL_WIDTH-1:0] first_new;
  logic                 publish;

  // Accumulator with the current lane's sample merged in
  always_comb begin
    samp_vec = accum_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == SEL_WIDTH'(i + 1)) begin
        samp_vec[i] = COLSCAN_Hit_In & COLSCAN_LaneMask_In[i];
      end
    end
  end

  colscan_prio_enc #(
    .NUM_LANES(NUM_LANES),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_enc (
    .vec_i (samp_vec),
    .lane_o(first_new)
  );

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    dwell_d  = dwell_q;
    accum_d  = accum_q;
    hitvec_d = hitvec_q;
    first_d  = first_q;
    publish  = 1'b0;
    unique case (state_q)
      COLSCAN_IDLE: begin
        if (COLSCAN_Start_In) begin
          state_d = COLSCAN_SCAN;
          lane_d  = SEL_WIDTH'(1);
          dwell_d = '0;
          accum_d = '0;
        end
      end
      COLSCAN_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          accum_d = samp_vec;
          dwell_d = '0;
          if (lane_q == LANE_LAST) begin
            state_d  = COLSCAN_DONE;
            publish  = 1'b1;
            hitvec_d = samp_vec;
            first_d  = first_new;
          end else begin
            lane_d = lane_q + SEL_WIDTH'(1);
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      COLSCAN_DONE: state_d = COLSCAN_IDLE;
      default:      state_d = COLSCAN_IDLE;
    endcase
  end

  always_ff @(posedge COLSCAN_CLOCK_50) begin
    if (COLSCAN_RESET_InHigh) begin
      state_q  <= COLSCAN_IDLE;
      lane_q   <= '0;
      dwell_q  <= '0;
      accum_q  <= '0;
      hitvec_q <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      dwell_q  <= dwell_d;
      accum_q  <= accum_d;
      hitvec_q <= hitvec_d;
      first_q  <= first_d;
    end
  end

`ifdef COLSCAN_STICKY_EN
  logic coll_q, coll_d;

  // A new hit wins over a simultaneous clear
  always_comb begin
    coll_d = coll_q;
    if (publish && (|samp_vec)) coll_d = 1'b1;
    else if (COLSCAN_Clear_In)  coll_d = 1'b0;
  end

  always_ff @(posedge COLSCAN_CLOCK_50) begin
    if (COLSCAN_RESET_InHigh) coll_q <= 1'b0;
    else                      coll_q <= coll_d;
  end

  assign COLSCAN_Collision_Out = coll_q;
`else
  logic unused_clear;
  logic unused_publish;
  assign unused_clear          = COLSCAN_Clear_In;
  assign unused_publish        = publish;
  assign COLSCAN_Collision_Out = |hitvec_q;
`endif

  assign COLSCAN_Select_Out = (state_q == COLSCAN_SCAN) ?
                              lane_q : SEL_WIDTH'(SEL_NONE);
  assign COLSCAN_HitVec_Out    = hitvec_q;
  assign COLSCAN_FirstLane_Out = first_q;
  assign COLSCAN_Busy_Out      = (state_q != COLSCAN_IDLE);
  assign COLSCAN_Done_Out      = (state_q == COLSCAN_DONE);

endmodule

// File: tb/tb_collision_lane_scanner.sv
// Bench for collision_lane_scanner: DWELL=1 and DWELL=3 instances
// against a phase-count reference model plus directed literal checks.
module tb_collision_lane_scanner;

  localparam int N = 7;

  logic       clk = 1'b0;
  logic       rst, start, clr, cmp_en;
  logic [6:0] mask, lanes_hit, noise;
  logic       hit0, hit3;
  logic [2:0] sel0, sel3, fl0, fl3;
  logic [6:0] hv0, hv3;
  logic       col0, col3, busy0, busy3, done0, done3;
  int         checks = 0;
  int         passed = 0;
  int         nd0 = 0;
  int         nd3 = 0;
  int         lat0, lat3;
  int         seq0 [7];

  always #5 clk = ~clk;

  collision_lane_scanner u0 (
    .COLSCAN_CLOCK_50     (clk),
    .COLSCAN_RESET_InHigh (rst),
    .COLSCAN_Start_In     (start),
    .COLSCAN_LaneMask_In  (mask),
    .COLSCAN_Hit_In       (hit0),
    .COLSCAN_Clear_In     (clr),
    .COLSCAN_Select_Out   (sel0),
    .COLSCAN_HitVec_Out   (hv0),
    .COLSCAN_Collision_Out(col0),
    .COLSCAN_FirstLane_Out(fl0),
    .COLSCAN_Busy_Out     (busy0),
    .COLSCAN_Done_Out     (done0)
  );

  collision_lane_scanner #(.DWELL(3)) u3 (
    .COLSCAN_CLOCK_50     (clk),
    .COLSCAN_RESET_InHigh (rst),
    .COLSCAN_Start_In     (start),
    .COLSCAN_LaneMask_In  (mask),
    .COLSCAN_Hit_In       (hit3),
    .COLSCAN_Clear_In     (clr),
    .COLSCAN_Select_Out   (sel3),
    .COLSCAN_HitVec_Out   (hv3),
    .COLSCAN_Collision_Out(col3),
    .COLSCAN_FirstLane_Out(fl3),
    .COLSCAN_Busy_Out     (busy3),
    .COLSCAN_Done_Out     (done3)
  );

  // phase: -1 idle, 0..N*d-1 scanning, N*d done
  typedef struct {
    int         phase;
    logic [6:0] acc;
    logic [6:0] hv;
    logic [2:0] first;
    logic       coll;
  } mdl_t;

  mdl_t m0 = '{-1, 7'd0, 7'd0, 3'd0, 1'b0};
  mdl_t m3 = '{-1, 7'd0, 7'd0, 3'd0, 1'b0};

  function automatic logic bit_at(logic [6:0] v, logic [2:0] s);
    if (s == 3'd0) return 1'b0;
    return v[s - 3'd1];
  endfunction

  function automatic logic [2:0] lowest(logic [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  function automatic mdl_t step(mdl_t s, int d, logic r, logic st,
                                logic h, logic c, logic [6:0] mk);
    mdl_t n;
    n = s;
    if (r) begin
      n.phase = -1; n.acc = 0; n.hv = 0; n.first = 0; n.coll = 0;
      return n;
    end
    if (s.phase < 0) begin
      if (st) begin n.phase = 0; n.acc = 0; end
    end else if (s.phase < N * d) begin
      if (s.phase % d == d - 1) n.acc[s.phase / d] = h & mk[s.phase / d];
      n.phase = s.phase + 1;
      if (n.phase == N * d) begin
        n.hv    = n.acc;
        n.first = lowest(n.acc);
      end
    end else begin
      n.phase = -1;
    end
`ifdef COLSCAN_STICKY_EN
    if (n.phase == N * d && s.phase != N * d && n.hv != 0) n.coll = 1'b1;
    else if (c) n.coll = 1'b0;
`else
    n.coll = |n.hv;
`endif
    return n;
  endfunction

  function automatic logic [2:0] exp_sel(mdl_t s, int d);
    if (s.phase >= 0 && s.phase < N * d) return 3'(s.phase / d + 1);
    return 3'd0;
  endfunction

  // Mux model: u3 sees noise except on the last dwell cycle of a lane
  assign hit0 = bit_at(lanes_hit, sel0);
  assign hit3 = (m3.phase >= 0 && m3.phase % 3 == 2) ?
                bit_at(lanes_hit, sel3) : bit_at(noise, sel3);

  always @(posedge clk) begin
    m0 <= step(m0, 1, rst, start, hit0, clr, mask);
    m3 <= step(m3, 3, rst, start, hit3, clr, mask);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (done0) nd0++;
    if (done3) nd3++;
    if (cmp_en) begin
      chk("m0_sel",   sel0,  exp_sel(m0, 1));
      chk("m0_busy",  busy0, int'(m0.phase >= 0));
      chk("m0_done",  done0, int'(m0.phase == N));
      chk("m0_hv",    hv0,   m0.hv);
      chk("m0_first", fl0,   m0.first);
      chk("m0_coll",  col0,  m0.coll);
      chk("m3_sel",   sel3,  exp_sel(m3, 3));
      chk("m3_busy",  busy3, int'(m3.phase >= 0));
      chk("m3_done",  done3, int'(m3.phase == 3 * N));
      chk("m3_hv",    hv3,   m3.hv);
      chk("m3_first", fl3,   m3.first);
      chk("m3_coll",  col3,  m3.coll);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; lat counts edges after the start-sampling edge
  task automatic run_scan(output int l0, output int l3);
    pulse_start();
    l0 = -1;
    l3 = -1;
    for (int k = 0; k < 60; k++) begin
      if (k < 7) seq0[k] = int'(sel0);
      if (done0 && l0 < 0) l0 = k;
      if (done3 && l3 < 0) l3 = k;
      if (l0 >= 0 && l3 >= 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, d3;
    rst = 1'b1; start = 1'b0; clr = 1'b0; cmp_en = 1'b0;
    mask = 7'h7F; lanes_hit = 7'h00; noise = 7'h00;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk);
    chk("idle_done_cnt", nd0 + nd3, 0);
    chk("idle_sel", sel0, 0);
    chk("idle_busy", busy0, 0);
    chk("idle_hv", hv0, 0);
    chk("idle_first", fl0, 0);

    // Single scan, hits on lanes 3 and 6
    lanes_hit = 7'b0100100;
    run_scan(lat0, lat3);
    chk("s2_latency", lat0, 7);
    for (int k = 0; k < 7; k++) chk("s2_sel_seq", seq0[k], k + 1);
    chk("s2_hv", hv0, 7'b0100100);
    chk("s2_first", fl0, 3);
    chk("s2_coll", col0, 1);
    chk("s2_hv3", hv3, 7'b0100100);

`ifndef COLSCAN_STICKY_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ignored", col0, 1);
`endif

    // Masked lane 3
    mask = 7'b1111011;
    run_scan(lat0, lat3);
    chk("s3_hv", hv0, 7'b0100000);
    chk("s3_first", fl0, 6);
    chk("s3_coll", col0, 1);

    // DWELL=3 with sampling only on the third cycle of a lane
    mask = 7'h7F;
    lanes_hit = 7'b0000010;
    noise = 7'b1111111;
    run_scan(lat0, lat3);
    chk("s4_latency3", lat3, 21);
    chk("s4_hv3", hv3, 7'b0000010);
    chk("s4_first3", fl3, 2);
    noise = 7'h00;

    // Start re-pulsed mid-scan
    lanes_hit = 7'b1000000;
    d0 = nd0;
    d3 = nd3;
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (30) @(negedge clk);
    chk("s5_one_done0", nd0 - d0, 1);
    chk("s5_one_done3", nd3 - d3, 1);
    chk("s5_hv", hv0, 7'b1000000);
    chk("s5_first", fl0, 7);

    // Reset while lane 4 is selected
    lanes_hit = 7'b0000001;
    d0 = nd0;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (sel0 == 3'd4) break;
      @(negedge clk);
    end
    chk("s5_reach4", sel0, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5_rst_sel", sel0, 0);
    chk("s5_rst_hv", hv0, 0);
    chk("s5_rst_coll", col0, 0);
    repeat (30) @(negedge clk);
    chk("s5_rst_nodone", nd0 - d0, 0);

`ifdef COLSCAN_STICKY_EN
    lanes_hit = 7'b0010000;
    run_scan(lat0, lat3);
    chk("st_set", col0, 1);
    lanes_hit = 7'b0000000;
    run_scan(lat0, lat3);
    chk("st_hold_hv", hv0, 0);
    chk("st_hold", col0, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("st_clear", col0, 0);
    lanes_hit = 7'b0000100;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (sel0 == 3'd7) break;
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("st_race_done", done0, 1);
    chk("st_race_set", col0, 1);
    repeat (25) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
